// File: rtl/quant_scheduler_pkg.sv
// Shared constants for the quantization scheduler: default fixed-point formats
// and the FIFO entry layout {sat, id, data}.
package quant_scheduler_pkg;

  localparam int IN_INT_DEF  = 18;
  localparam int IN_DEC_DEF  = 16;
  localparam int OUT_INT_DEF = 8;
  localparam int OUT_DEC_DEF = 8;

  localparam int IN_W  = IN_INT_DEF + IN_DEC_DEF;
  localparam int OUT_W = OUT_INT_DEF + OUT_DEC_DEF;

  localparam int SAT_CNT_W = 16;

  // Entry layout, MSB first: {sat, id, data}
  function automatic int entry_width(input int id_w, input int out_w);
    return 1 + id_w + out_w;
  endfunction

endpackage

// File: rtl/quant_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr_i and returns the first
// set bit as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/quant_scheduler.sv
// Shares one Q(IN_INT).(IN_DEC) -> Q(OUT_INT).(OUT_DEC) truncating/saturating
// quantizer among N_REQ requesters; results go to a 2-entry tagged FIFO.
module quant_scheduler
  import quant_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IN_INT  = IN_INT_DEF,
  parameter int IN_DEC  = IN_DEC_DEF,
  parameter int OUT_INT = OUT_INT_DEF,
  parameter int OUT_DEC = OUT_DEC_DEF,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*(IN_INT+IN_DEC)-1:0]     req_data,
  output logic [N_REQ-1:0]                     req_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_INT+OUT_DEC-1:0]           out_data,
  output logic [ID_W-1:0]                      out_id,
  output logic                                 out_sat,
  output logic [SAT_CNT_W-1:0]                 sat_cnt,
  input  logic                                 cnt_clr
);

  localparam int IW = IN_INT + IN_DEC;
  localparam int OW = OUT_INT + OUT_DEC;
  localparam int EW = entry_width(ID_W, OW);

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [EW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [IW-1:0]     sel;
  logic [IN_INT-1:0] in_int;
  logic [IN_DEC-1:0] in_dec;
  logic              ovf;
  logic [OW-1:0]     q_val;
  logic [EW-1:0]     ent;
  logic              space, push, pop;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign out_valid = (cnt_q != 2'd0);
  assign out_sat   = head_q[EW-1];
  assign out_id    = head_q[OW +: ID_W];
  assign out_data  = head_q[OW-1:0];
  assign sat_cnt   = sat_cnt_q;

  assign pop       = out_valid & out_ready;
  assign space     = (cnt_q < 2'd2) | pop;
  assign req_ready = gnt & {N_REQ{space}};
  assign push      = gnt_any & space;

  // Shift form of the overflow test stays legal when OUT_INT == IN_INT.
  always_comb begin
    sel    = req_data[int'(gnt_idx)*IW +: IW];
    in_int = sel[IW-1:IN_DEC];
    in_dec = sel[IN_DEC-1:0];
    ovf    = (in_int >> OUT_INT) != '0;
    q_val  = ovf ? {OW{1'b1}} : {in_int[OUT_INT-1:0], in_dec[IN_DEC-1 -: OUT_DEC]};
    ent    = {ovf, gnt_idx, q_val};
  end

  // Head/tail register pair; head keeps its last value once drained.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = ent;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = ent;
        end else if (push) begin
          tail_d = ent;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = ent;
          else      cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (push) ptr_d = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + ID_W'(1);
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr)
      sat_cnt_d = '0;
    else if (push && ovf && (sat_cnt_q != {SAT_CNT_W{1'b1}}))
      sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= 2'd0;
      sat_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_quant_scheduler.sv
// Directed bench for quant_scheduler: arbitration order, quantization,
// saturation counting, FIFO backpressure and async reset.
module tb_quant_scheduler;

  localparam int N  = 4;
  localparam int IW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*IW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [1:0]    out_id;
  logic          out_sat;
  logic [15:0]   sat_cnt;
  logic          cnt_clr;

  int vectors = 0;
  int miscompares = 0;

  quant_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_sat   (out_sat),
    .sat_cnt   (sat_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [17:0] ip, input logic [15:0] dp);
    req_valid[i]          = v;
    req_data[i*IW +: IW]  = {ip, dp};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i "pattern" data: int = i*16+1, dec = 0x8000 -> out = {i*16+1, 0x80}
  function automatic logic [15:0] pat_out(input int i);
    logic [7:0] hi;
    hi = 8'(i*16 + 1);
    return {hi, 8'h80};
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_id",    32'(out_id),    32'h0);
    chk("rst_out_sat",   32'(out_sat),   32'h0);
    chk("rst_sat_cnt",   32'(sat_cnt),   32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // single request from req 0
    set_req(0, 1'b1, 18'h000B4, 16'hB200);
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 18'h000B4, 16'hB200);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data",  32'(out_data),  32'hB4B2);
    chk("single_id",    32'(out_id),    32'h0);
    chk("single_sat",   32'(out_sat),   32'h0);
    tick();
    chk("drain_valid",  32'(out_valid), 32'h0);
    chk("drain_hold",   32'(out_data),  32'hB4B2);

    // overflow from req 2 (ptr=1)
    set_req(2, 1'b1, 18'h00100, 16'h0000);
    #1 chk("ovf_ready", 32'(req_ready), 32'h4);
    tick();
    chk("ovf_data",  32'(out_data), 32'hFFFF);
    chk("ovf_id",    32'(out_id),   32'h2);
    chk("ovf_sat",   32'(out_sat),  32'h1);
    chk("ovf_cnt",   32'(sat_cnt),  32'h1);
    // ptr=3 now; req 2 alone must win via wrap; cnt_clr beats the increment
    cnt_clr = 1'b1;
    #1 chk("wrap_ready", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 18'h00100, 16'h0000);
    cnt_clr = 1'b0;
    chk("clr_cnt",   32'(sat_cnt),   32'h0);
    chk("clr_valid", 32'(out_valid), 32'h1);
    chk("clr_id",    32'(out_id),    32'h2);
    tick();
    chk("clr_drain", 32'(out_valid), 32'h0);

    // all valid, ptr=3: grants 3,0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 18'(i*16 + 1), 16'h8000);
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1 << ((3 + k) % 4)));
      tick();
      chk("rr_id",   32'(out_id),   32'((3 + k) % 4));
      chk("rr_data", 32'(out_data), 32'(pat_out((3 + k) % 4)));
    end
    req_valid = '0;
    tick();
    chk("rr_drain", 32'(out_valid), 32'h0);

    // backpressure, ptr=1: reqs 1 and 3
    out_ready = 1'b0;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    #1 chk("bp_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("bp_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("bp_full_ready", 32'(req_ready), 32'h0);
    chk("bp_head_id",    32'(out_id),    32'h1);
    tick();
    chk("bp_stall_ready", 32'(req_ready), 32'h0);
    chk("bp_stall_id",    32'(out_id),    32'h1);
    chk("bp_stall_data",  32'(out_data),  32'h1180);
    out_ready = 1'b1;
    #1 chk("bp_pp_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("bp_pop1_id",  32'(out_id),   32'h3);
    chk("bp_pop1_data", 32'(out_data), 32'h3180);
    chk("bp_pp_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    chk("bp_pop3_id", 32'(out_id), 32'h1);
    tick();
    chk("bp_cnt2_valid", 32'(out_valid), 32'h1);
    chk("bp_cnt2_id",    32'(out_id),    32'h3);
    tick();
    chk("bp_empty", 32'(out_valid), 32'h0);

    // fill FIFO (ptr=0) with a saturating req 0 then req 1, then async reset
    out_ready = 1'b0;
    set_req(0, 1'b1, 18'h3FFFF, 16'h1234);
    for (int i = 1; i < N; i++) set_req(i, 1'b1, 18'(i*16 + 1), 16'h8000);
    tick();
    tick();
    chk("pre_rst_ready", 32'(req_ready), 32'h0);
    chk("pre_rst_sat",   32'(out_sat),   32'h1);
    chk("pre_rst_data",  32'(out_data),  32'hFFFF);
    chk("pre_rst_cnt",   32'(sat_cnt),   32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cnt",   32'(sat_cnt),   32'h0);
    chk("mid_rst_data",  32'(out_data),  32'h0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_id",  32'(out_id),    32'h0);
    chk("post_rst_cnt", 32'(sat_cnt),   32'h1);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
